state_dump_ctrl: RTL and testbench
==================================

STATE_DUMP_CTRL -- requirements
Module: state_dump_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of PC, register and output data.
REQ-002 SHALL have parameter REG_NUM, default 32, number of register-file entries dumped (power of 2).
REQ-003 SHALL have parameter MEM_BYTES, default 32, number of data-memory bytes dumped (power of 2).
REQ-004 SHALL have parameter MAX_COUNT, default 17, cycle count after reset release that triggers the dump.
REQ-005 SHALL have parameter CNT_W, default 16, cycle-counter width.
REQ-006 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port trig_i, input, 1, external dump request; sampled only in IDLE.
REQ-009 SHALL have port pc_i, input, DATA_W, current CPU PC, captured at trigger.
REQ-010 SHALL have port reg_addr_o, output, log2(REG_NUM), register-file read address.
REQ-011 SHALL have port reg_data_i, input, DATA_W, combinational register-file read data.
REQ-012 SHALL have port mem_addr_o, output, log2(MEM_BYTES), data-memory byte address.
REQ-013 SHALL have port mem_data_i, input, 8, combinational data-memory byte.
REQ-014 SHALL have port dump_valid_o, output, 1; dump_ready_i, input, 1; valid/ready stream handshake.
REQ-015 SHALL have port dump_data_o, output, DATA_W, and dump_tag_o, output, 2 (00 header, 01 register, 10 memory, 11 end).
REQ-016 SHALL have port dump_idx_o, output, CNT_W, entry index, or the cycle count on the header beat.
REQ-017 SHALL have ports halt_o and done_o, output, 1 each; halt_o requests a CPU freeze, done_o flags dump completion.

Function
REQ-018 SHALL implement FSM states IDLE, HDR, REG, MEM, END, DONE.
REQ-019 IDLE: cycle counter SHALL increment every cycle, saturating at all-ones.
REQ-020 IDLE: trigger SHALL fire when counter == MAX_COUNT or trig_i=1; both in the same cycle give one dump.
REQ-021 On trigger: pc_i and counter SHALL be captured, halt_o SHALL assert the next cycle and hold until reset, and the FSM SHALL go to HDR.
REQ-022 Output register SHALL load only when dump_valid_o=0 or dump_ready_i=1; dump_data_o/tag/idx SHALL stay stable while valid=1 and ready=0.
REQ-023 HDR: one beat, tag 00, data = captured PC, idx = captured count; then REG.
REQ-024 REG: REG_NUM beats, idx 0..REG_NUM-1, data = reg_data_i at reg_addr_o = idx; then MEM.
REQ-025 MEM: MEM_BYTES beats, data = zero-extended mem_data_i at mem_addr_o = idx; then END.
REQ-026 END: one beat, tag 11, data 0, idx = total beats sent (REG_NUM+MEM_BYTES+1); after its acceptance the FSM enters DONE.
REQ-027 DONE SHALL be terminal: done_o=1, dump_valid_o=0; trig_i ignored until reset.
REQ-028 trig_i outside IDLE SHALL be ignored; dump_ready_i held low SHALL stall indefinitely without losing beats.
REQ-029 Throughput SHALL be one beat per cycle with ready held high; first valid beat SHALL appear 1 cycle after the trigger cycle.
REQ-030 Index counters SHALL wrap to 0 on state change; no beat skipped or duplicated.

Reset
REQ-031 While rst_i=0: state=IDLE, counter=0, all outputs 0 (dump_valid_o, halt_o, done_o, addresses, data, tag, idx).
REQ-032 Reset asserted mid-dump SHALL abort immediately; after release a fresh count starts from 0.

Structure
REQ-033 Tag encodings and FSM state encoding SHALL live in shared package dump_pkg.
REQ-034 One sub-module, dump_cycle_cnt (saturating, CNT_W-wide, enable/clear), SHALL be instantiated; everything else is flat.

Verification
REQ-035 Defaults, ready=1, pc_i=0x40 -> header at cycle 18 after release with data 0x40, idx 17; 32 reg beats, 32 mem beats, end idx 65; done_o=1.
REQ-036 trig_i=1 at cycle 5 -> header idx 5; a second trig_i at cycle 10 -> no effect.
REQ-037 ready toggling 1/0 every cycle -> 66 beats delivered in order, data stable during stalls, no duplicates.
REQ-038 Reset at register beat 10 -> all outputs 0 asynchronously; after release the dump restarts and header idx = 17.
REQ-039 MAX_COUNT=3, REG_NUM=4, MEM_BYTES=8, mem byte 0xFF -> memory beat data 0x000000FF, end idx 13.
REQ-040 trig_i=1 in the same cycle as counter == MAX_COUNT -> exactly one header beat.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared encodings for the state-dump controller: FSM states and beat tags.
package dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_REG  = 3'd2,
    ST_MEM  = 3'd3,
    ST_END  = 3'd4,
    ST_DONE = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    TAG_HDR = 2'b00,
    TAG_REG = 2'b01,
    TAG_MEM = 2'b10,
    TAG_END = 2'b11
  } tag_e;

endpackage

// File: rtl/dump_cycle_cnt.sv
// Saturating cycle counter with synchronous clear and count enable.
module dump_cycle_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stops at all-ones instead of rolling over to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/state_dump_ctrl.sv
// Halts the CPU after a cycle budget or an external request and streams a
// header, the register file, the data memory and an end marker over a
// valid/ready interface. The FSM state names the beat held in the output
// register; the beat-generation logic builds the beat that follows it.
module state_dump_ctrl
  import dump_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_NUM   = 32,
  parameter int MEM_BYTES = 32,
  parameter int MAX_COUNT = 17,
  parameter int CNT_W     = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         trig_i,
  input  logic [DATA_W-1:0]            pc_i,
  output logic [$clog2(REG_NUM)-1:0]   reg_addr_o,
  input  logic [DATA_W-1:0]            reg_data_i,
  output logic [$clog2(MEM_BYTES)-1:0] mem_addr_o,
  input  logic [7:0]                   mem_data_i,
  output logic                         dump_valid_o,
  input  logic                         dump_ready_i,
  output logic [DATA_W-1:0]            dump_data_o,
  output logic [1:0]                   dump_tag_o,
  output logic [CNT_W-1:0]             dump_idx_o,
  output logic                         halt_o,
  output logic                         done_o
);

  localparam int RAW = $clog2(REG_NUM);
  localparam int MAW = $clog2(MEM_BYTES);

  state_e           state_q, state_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_en, trig_fire, load, last_reg, last_mem;
  logic [RAW-1:0]   reg_addr;
  logic [MAW-1:0]   mem_addr;

  logic             vld_p0, vld_p1;
  logic [DATA_W-1:0] data_p0, data_p1;
  tag_e             tag_p0, tag_p1;
  logic [CNT_W-1:0] idx_p0, idx_p1;

  assign cnt_en = (state_q == ST_IDLE);

  dump_cycle_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (cnt_en),
    .clr_i (trig_fire),
    .cnt_o (cnt)
  );

  // Budget expiry and external request collapse into a single trigger.
  assign trig_fire = (state_q == ST_IDLE) && ((cnt == CNT_W'(MAX_COUNT)) || trig_i);
  // The output register may take a new beat when empty or when its beat is taken.
  assign load      = !vld_p1 || dump_ready_i;
  assign last_reg  = (idx_p1 == CNT_W'(REG_NUM - 1));
  assign last_mem  = (idx_p1 == CNT_W'(MEM_BYTES - 1));

  // Control state: FSM and sticky halt request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // Next state: advance only when the held beat is replaced.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q | trig_fire;
    case (state_q)
      ST_IDLE: if (trig_fire)           state_d = ST_HDR;
      ST_HDR:  if (load)                state_d = ST_REG;
      ST_REG:  if (load && last_reg)    state_d = ST_MEM;
      ST_MEM:  if (load && last_mem)    state_d = ST_END;
      ST_END:  if (load)                state_d = ST_DONE;
      ST_DONE:                          state_d = ST_DONE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Stage p0: build the beat following the one held, and the read address it needs.
  always_comb begin
    vld_p0   = 1'b0;
    data_p0  = '0;
    tag_p0   = TAG_HDR;
    idx_p0   = '0;
    reg_addr = '0;
    mem_addr = '0;
    case (state_q)
      ST_IDLE: begin
        if (trig_fire) begin
          vld_p0  = 1'b1;
          data_p0 = pc_i;
          tag_p0  = TAG_HDR;
          idx_p0  = cnt;
        end
      end
      ST_HDR: begin
        vld_p0  = 1'b1;
        data_p0 = reg_data_i;
        tag_p0  = TAG_REG;
      end
      ST_REG: begin
        vld_p0 = 1'b1;
        if (last_reg) begin
          data_p0 = DATA_W'(mem_data_i);
          tag_p0  = TAG_MEM;
        end else begin
          reg_addr = idx_p1[RAW-1:0] + RAW'(1);
          data_p0  = reg_data_i;
          tag_p0   = TAG_REG;
          idx_p0   = idx_p1 + CNT_W'(1);
        end
      end
      ST_MEM: begin
        vld_p0 = 1'b1;
        if (last_mem) begin
          tag_p0 = TAG_END;
          idx_p0 = CNT_W'(REG_NUM + MEM_BYTES + 1);
        end else begin
          mem_addr = idx_p1[MAW-1:0] + MAW'(1);
          data_p0  = DATA_W'(mem_data_i);
          tag_p0   = TAG_MEM;
          idx_p0   = idx_p1 + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Stage p1: output register, held while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      tag_p1  <= TAG_HDR;
      idx_p1  <= '0;
    end else if (load) begin
      vld_p1  <= vld_p0;
      data_p1 <= data_p0;
      tag_p1  <= tag_p0;
      idx_p1  <= idx_p0;
    end
  end

  assign reg_addr_o   = reg_addr;
  assign mem_addr_o   = mem_addr;
  assign dump_valid_o = vld_p1;
  assign dump_data_o  = data_p1;
  assign dump_tag_o   = tag_p1;
  assign dump_idx_o   = idx_p1;
  assign halt_o       = halt_q;
  assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_state_dump_ctrl.sv
// Bench for state_dump_ctrl: default-size instance driven from a scenario
// table plus hand sequences, and a small instance for the reduced sizes.
module tb_state_dump_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst_n, trig, rdy;
  logic [31:0] pc, reg_data, data;
  logic [4:0]  reg_addr, mem_addr;
  logic [7:0]  mem_data;
  logic        vld, halt, done;
  logic [1:0]  tag;
  logic [15:0] idx;
  logic [15:0] seed;

  assign reg_data = 32'hA500_0000 ^ {seed, 11'd0, reg_addr};
  assign mem_data = {mem_addr, 3'b101} ^ seed[7:0];

  state_dump_ctrl u_dut (
    .clk_i(clk), .rst_i(rst_n), .trig_i(trig), .pc_i(pc),
    .reg_addr_o(reg_addr), .reg_data_i(reg_data),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .dump_valid_o(vld), .dump_ready_i(rdy),
    .dump_data_o(data), .dump_tag_o(tag), .dump_idx_o(idx),
    .halt_o(halt), .done_o(done)
  );

  // Reduced instance
  logic        rst_s, trig_s, rdy_s;
  logic [31:0] pc_s, reg_data_s, data_s;
  logic [1:0]  reg_addr_s;
  logic [2:0]  mem_addr_s;
  logic [7:0]  mem_data_s;
  logic        vld_s, halt_s, done_s;
  logic [1:0]  tag_s;
  logic [15:0] idx_s;

  assign reg_data_s = {seed, 14'd0, reg_addr_s};
  assign mem_data_s = 8'hFF;

  state_dump_ctrl #(.MAX_COUNT(3), .REG_NUM(4), .MEM_BYTES(8)) u_small (
    .clk_i(clk), .rst_i(rst_s), .trig_i(trig_s), .pc_i(pc_s),
    .reg_addr_o(reg_addr_s), .reg_data_i(reg_data_s),
    .mem_addr_o(mem_addr_s), .mem_data_i(mem_data_s),
    .dump_valid_o(vld_s), .dump_ready_i(rdy_s),
    .dump_data_o(data_s), .dump_tag_o(tag_s), .dump_idx_o(idx_s),
    .halt_o(halt_s), .done_o(done_s)
  );

  typedef struct {
    logic [31:0] pc;
    int          t1;
    int          t2;
    int          mode;   // 0 ready high, 1 toggling, 2 random
    int          hidx;
    int          hcyc;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] sb[$];
  logic [63:0] sb_s[$];
  int          n_checks, n_fail;
  int          cyc, cyc_s, first_cyc, first_cyc_s, beats, beats_s;
  logic        stall_pend;
  logic [63:0] p_beat;
  logic        found;

  function automatic logic [63:0] pack(input logic [1:0] t, input logic [15:0] i, input logic [31:0] d);
    return {14'd0, t, i, d};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push_dump(input logic [31:0] hpc, input int hidx);
    sb.push_back(pack(2'd0, 16'(hidx), hpc));
    for (int i = 0; i < 32; i++) sb.push_back(pack(2'd1, 16'(i), 32'hA500_0000 ^ {seed, 11'd0, 5'(i)}));
    for (int i = 0; i < 32; i++) sb.push_back(pack(2'd2, 16'(i), {24'd0, {5'(i), 3'b101} ^ seed[7:0]}));
    sb.push_back(pack(2'd3, 16'd65, 32'd0));
  endtask

  // One clock: compare at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    logic [63:0] e;
    @(negedge clk);
    if (!rst_n) begin
      stall_pend = 1'b0;
      first_cyc  = -1;
      beats      = 0;
    end else begin
      if (stall_pend) check("stall_hold", {13'd0, vld, tag, idx, data}, {13'd0, 1'b1, p_beat[49:0]});
      if (vld && first_cyc < 0) begin
        first_cyc = cyc;
        check("halt_at_header", 64'(halt), 64'd1);
      end
      if (vld && rdy) begin
        beats++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_beat: got=%h expected=none", pack(tag, idx, data));
        end else begin
          e = sb.pop_front();
          check("beat", pack(tag, idx, data), e);
        end
      end
      stall_pend = vld && !rdy;
      p_beat     = pack(tag, idx, data);
    end
    if (!rst_s) begin
      first_cyc_s = -1;
      beats_s     = 0;
    end else if (vld_s && rdy_s) begin
      if (first_cyc_s < 0) first_cyc_s = cyc_s;
      beats_s++;
      if (sb_s.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL small_extra_beat: got=%h expected=none", pack(tag_s, idx_s, data_s));
      end else begin
        e = sb_s.pop_front();
        check("small_beat", pack(tag_s, idx_s, data_s), e);
      end
    end
    @(posedge clk);
    cyc   = rst_n ? cyc + 1 : 0;
    cyc_s = rst_s ? cyc_s + 1 : 0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    trig  = 1'b0;
    rdy   = 1'b1;
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0; cyc_s = 0;
    first_cyc = -1; first_cyc_s = -1; beats = 0; beats_s = 0;
    stall_pend = 1'b0; p_beat = '0; found = 1'b0;
    rst_n = 1'b0; rst_s = 1'b0; trig = 1'b0; trig_s = 1'b0;
    rdy = 1'b1; rdy_s = 1'b1; pc = '0; pc_s = '0; seed = '0;

    vecs[0] = '{32'h0000_0040, -1,  -1, 0, 17, 18};
    vecs[1] = '{32'h1234_5678,  5,  10, 0,  5,  6};
    vecs[2] = '{32'hCAFE_0001, -1,  -1, 1, 17, 18};
    vecs[3] = '{32'hDEAD_BEEF, 17, 200, 0, 17, 18};
    vecs[4] = '{32'h8000_0000,  0,  -1, 2,  0,  1};

    step();
    step();
    check("reset_outputs", {1'b0, vld, halt, done, reg_addr, mem_addr, tag, idx, data}, 64'd0);
    check("reset_outputs_small", {6'd0, vld_s, halt_s, done_s, reg_addr_s, mem_addr_s, tag_s, idx_s, data_s}, 64'd0);

    for (int r = 0; r < 5; r++) begin
      seed = 16'(r * 16'h1357 + 16'h2468);
      pc   = vecs[r].pc;
      do_reset();
      push_dump(pc, vecs[r].hidx);
      for (int c = 0; c < 250; c++) begin
        trig = (c == vecs[r].t1) || (c == vecs[r].t2);
        rdy  = (vecs[r].mode == 0) ? 1'b1 :
               (vecs[r].mode == 1) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
        step();
      end
      trig = 1'b0;
      check("done", 64'(done), 64'd1);
      check("valid_after_done", 64'(vld), 64'd0);
      check("halt_held", 64'(halt), 64'd1);
      check("all_beats_seen", 64'(sb.size()), 64'd0);
      check("header_cycle", 64'(first_cyc), 64'(vecs[r].hcyc));
      check("beat_count", 64'(beats), 64'd66);
    end

    // Reset in the middle of the register section, then a fresh dump.
    seed = 16'h5A5A;
    pc   = 32'h0000_0BAD;
    do_reset();
    push_dump(pc, 17);
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      step();
      if (vld && tag == 2'd1 && idx == 16'd10) found = 1'b1;
    end
    check("reach_reg_beat_10", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset", {1'b0, vld, halt, done, reg_addr, mem_addr, tag, idx, data}, 64'd0);
    sb.delete();
    step();
    step();
    rst_n = 1'b1;
    seed  = 16'h0F0F;
    push_dump(pc, 17);
    for (int c = 0; c < 120; c++) step();
    check("restart_header_cycle", 64'(first_cyc), 64'd18);
    check("restart_done", 64'(done), 64'd1);
    check("restart_all_beats", 64'(sb.size()), 64'd0);
    check("restart_beat_count", 64'(beats), 64'd66);

    // Reduced sizes with an all-ones memory byte.
    seed = 16'h3C3C;
    pc_s = 32'h0000_1000;
    sb_s.push_back(pack(2'd0, 16'd3, pc_s));
    for (int i = 0; i < 4; i++) sb_s.push_back(pack(2'd1, 16'(i), {seed, 14'd0, 2'(i)}));
    for (int i = 0; i < 8; i++) sb_s.push_back(pack(2'd2, 16'(i), 32'h0000_00FF));
    sb_s.push_back(pack(2'd3, 16'd13, 32'd0));
    rst_s = 1'b1;
    for (int c = 0; c < 40; c++) step();
    check("small_header_cycle", 64'(first_cyc_s), 64'd4);
    check("small_beat_count", 64'(beats_s), 64'd14);
    check("small_all_beats", 64'(sb_s.size()), 64'd0);
    check("small_done", 64'(done_s), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
